// File: rtl/bsg_demux_one_hot_buffered_if.sv
// Handshake bundle for the buffered one-hot demux: one producer-side word channel in,
// els_p independently drained output lanes plus the illegal-select status.
interface bsg_demux_one_hot_buffered_if #(
  parameter int width_p = 32,
  parameter int els_p   = 5
);
  logic                     v_i;
  logic                     ready_o;
  logic [width_p-1:0]       data_i;
  logic [els_p-1:0]         sel_one_hot_i;
  logic [els_p-1:0]         v_o;
  logic [els_p*width_p-1:0] data_o;
  logic [els_p-1:0]         yumi_i;
  logic                     err_o;
  logic [7:0]               err_cnt_o;

  modport master (
    output v_i, data_i, sel_one_hot_i, yumi_i,
    input  ready_o, v_o, data_o, err_o, err_cnt_o
  );

  modport slave (
    input  v_i, data_i, sel_one_hot_i, yumi_i,
    output ready_o, v_o, data_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/bsg_demux_one_hot_buffered.sv
// Steers each input word into one of els_p single-entry lane buffers; 1-cycle latency.
// Backpressure: ready_o drops only when the selected lane is full and not being drained.
module bsg_demux_one_hot_buffered #(
  parameter int width_p = 32,
  parameter int els_p   = 5
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  bsg_demux_one_hot_buffered_if.slave       io
);

  logic [els_p-1:0]              v_q, v_d;
  logic [els_p-1:0][width_p-1:0] data_q, data_d;
  logic                          err_q, err_d;
  logic [7:0]                    err_cnt_q, err_cnt_d;

  logic             sel_any, sel_multi, sel_legal;
  logic             ready;
  logic [els_p-1:0] wr;

  always_comb begin
    sel_any   = 1'b0;
    sel_multi = 1'b0;
    for (int k = 0; k < els_p; k++) begin
      if (io.sel_one_hot_i[k]) begin
        if (sel_any) sel_multi = 1'b1;
        sel_any = 1'b1;
      end
    end
  end

  assign sel_legal = sel_any & ~sel_multi;

  // Illegal selects are always swallowed so a bad producer can never stall the input.
  assign ready = sel_legal ? |(io.sel_one_hot_i & (~v_q | io.yumi_i)) : 1'b1;
  assign wr    = (io.v_i & ready & sel_legal) ? io.sel_one_hot_i : '0;

  always_comb begin
    v_d       = v_q;
    data_d    = data_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    for (int k = 0; k < els_p; k++) begin
      if (wr[k]) begin
        v_d[k]    = 1'b1;
        data_d[k] = io.data_i;
      end else if (io.yumi_i[k]) begin
        v_d[k] = 1'b0;
      end
    end
    if (io.v_i & ~sel_legal) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q       <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      v_q       <= v_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign io.ready_o   = ready;
  assign io.v_o       = v_q;
  assign io.data_o    = data_q;
  assign io.err_o     = err_q;
  assign io.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_bsg_demux_one_hot_buffered.sv
// Bench for bsg_demux_one_hot_buffered: per-lane expected-word queues filled on accepted
// transfers and drained on yumi, plus directed scenario tasks.
module tb_bsg_demux_one_hot_buffered;

  logic clk_i;
  logic reset_n_i;

  int checks;
  int failures;

  bsg_demux_one_hot_buffered_if #(.width_p(32), .els_p(5)) bus ();

  bsg_demux_one_hot_buffered #(.width_p(32), .els_p(5)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .io        (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [31:0] exp_q [5][$];
  logic        mon_v;
  logic [31:0] mon_d;

  function automatic logic [31:0] lane(input int k);
    return bus.data_o[k*32 +: 32];
  endfunction

  // Scoreboard: sampled mid-cycle, away from the rising edge.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      for (int k = 0; k < 5; k++) begin
        mon_v = (exp_q[k].size() != 0);
        checks++;
        if (bus.v_o[k] !== mon_v) begin
          failures++;
          $display("FAIL sb_valid lane %0d: got %b expected %b", k, bus.v_o[k], mon_v);
        end
        if (bus.yumi_i[k] && bus.v_o[k] && exp_q[k].size() != 0) begin
          mon_d = exp_q[k].pop_front();
          checks++;
          if (lane(k) !== mon_d) begin
            failures++;
            $display("FAIL sb_data lane %0d: got %h expected %h", k, lane(k), mon_d);
          end
        end
      end
      if (bus.v_i && bus.ready_o && $countones(bus.sel_one_hot_i) == 1) begin
        for (int k = 0; k < 5; k++)
          if (bus.sel_one_hot_i[k]) exp_q[k].push_back(bus.data_i);
      end
    end
  end

  always @(negedge reset_n_i) begin
    for (int k = 0; k < 5; k++) exp_q[k].delete();
  end

  task automatic drive(input logic v, input logic [4:0] sel, input logic [31:0] d,
                       input logic [4:0] y);
    bus.v_i           = v;
    bus.sel_one_hot_i = sel;
    bus.data_i        = d;
    bus.yumi_i        = y;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    drive(1'b1, 5'b00100, 32'hFFFF_FFFF, 5'b00000);
    #1;
    checks++;
    if (bus.v_o !== 5'b0 || bus.data_o !== 160'b0 || bus.err_o !== 1'b0 || bus.err_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: v_o=%b err=%b cnt=%0d data_nonzero=%b expected all zero",
               bus.v_o, bus.err_o, bus.err_cnt_o, |bus.data_o);
    end
    checks++;
    if (bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", bus.ready_o);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (bus.v_o !== 5'b0 || bus.data_o !== 160'b0) begin
      failures++;
      $display("FAIL reset_hold: v_o=%b expected 00000", bus.v_o);
    end
    reset_n_i = 1'b1;
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    next_cycle();
  endtask

  task automatic test_single();
    drive(1'b1, 5'b00100, 32'hDEAD_BEEF, 5'b0);
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o !== 5'b00100 || lane(2) !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_write: v_o=%b lane2=%h expected 00100 deadbeef", bus.v_o, lane(2));
    end
    checks++;
    if ((bus.data_o & ~{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0}) !== 160'b0) begin
      failures++;
      $display("FAIL single_others: other lanes nonzero, expected 0");
    end
    drive(1'b0, 5'b0, 32'h0, 5'b00100);
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o !== 5'b0 || lane(2) !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_drain_hold: v_o=%b lane2=%h expected 00000 deadbeef", bus.v_o, lane(2));
    end
  endtask

  task automatic test_idle_inputs();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'($urandom), $urandom, 5'b0);
      next_cycle();
    end
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o !== 5'b0 || lane(2) !== 32'hDEAD_BEEF || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_effect: v_o=%b lane2=%h err=%b expected 00000 deadbeef 0",
               bus.v_o, lane(2), bus.err_o);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 5'b00100, 32'h1111_1111, 5'b0);
    next_cycle();
    drive(1'b1, 5'b00100, 32'h2222_2222, 5'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready_low: got %b expected 0", bus.ready_o);
      end
      next_cycle();
      checks++;
      if (lane(2) !== 32'h1111_1111) begin
        failures++;
        $display("FAIL bp_hold: lane2=%h expected 11111111", lane(2));
      end
    end
    drive(1'b1, 5'b00100, 32'h2222_2222, 5'b00100);
    @(negedge clk_i);
    checks++;
    if (bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_yumi: got %b expected 1", bus.ready_o);
    end
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o !== 5'b00100 || lane(2) !== 32'h2222_2222) begin
      failures++;
      $display("FAIL bp_second: v_o=%b lane2=%h expected 00100 22222222", bus.v_o, lane(2));
    end
    drive(1'b0, 5'b0, 32'h0, 5'b00100);
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'b00001, 32'h0000_00C0, 5'b0);
    next_cycle();
    drive(1'b1, 5'b00001, 32'hA5A5_A5A5, 5'b00001);
    @(negedge clk_i);
    checks++;
    if (bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: got %b expected 1", bus.ready_o);
    end
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o[0] !== 1'b1 || lane(0) !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL b2b_replace: v0=%b lane0=%h expected 1 a5a5a5a5", bus.v_o[0], lane(0));
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'b00001, 32'h0000_0100 + 32'(i), 5'b00001);
      @(negedge clk_i);
      checks++;
      if (bus.ready_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_stream_ready: word %0d got %b expected 1", i, bus.ready_o);
      end
      next_cycle();
      checks++;
      if (bus.v_o[0] !== 1'b1 || lane(0) !== 32'h0000_0100 + 32'(i)) begin
        failures++;
        $display("FAIL b2b_stream_data: word %0d lane0=%h v0=%b", i, lane(0), bus.v_o[0]);
      end
    end
    drive(1'b0, 5'b0, 32'h0, 5'b00001);
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
  endtask

  task automatic test_illegal();
    drive(1'b1, 5'b01000, 32'h0000_0033, 5'b0);
    next_cycle();
    drive(1'b1, 5'b00000, 32'hBAD0_0000, 5'b0);
    @(negedge clk_i);
    checks++;
    if (bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL illegal_zero_ready: got %b expected 1", bus.ready_o);
    end
    next_cycle();
    drive(1'b1, 5'b10001, 32'hBAD0_0001, 5'b0);
    @(negedge clk_i);
    checks++;
    if (bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL illegal_multi_ready: got %b expected 1", bus.ready_o);
    end
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o !== 5'b01000 || lane(3) !== 32'h0000_0033 || bus.err_o !== 1'b1 || bus.err_cnt_o !== 8'd2) begin
      failures++;
      $display("FAIL illegal_two: v_o=%b lane3=%h err=%b cnt=%0d expected 01000 33 1 2",
               bus.v_o, lane(3), bus.err_o, bus.err_cnt_o);
    end
    for (int i = 0; i < 298; i++) begin
      drive(1'b1, (i % 3 == 0) ? 5'b00000 : ((i % 3 == 1) ? 5'b11000 : 5'b11111), $urandom, 5'b0);
      next_cycle();
    end
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.err_cnt_o !== 8'd255 || bus.err_o !== 1'b1 || bus.v_o !== 5'b01000) begin
      failures++;
      $display("FAIL illegal_saturate: cnt=%0d err=%b v_o=%b expected 255 1 01000",
               bus.err_cnt_o, bus.err_o, bus.v_o);
    end
    drive(1'b0, 5'b0, 32'h0, 5'b01000);
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
  endtask

  task automatic test_multi_drain();
    drive(1'b1, 5'b00010, 32'h1111_0001, 5'b0);
    next_cycle();
    drive(1'b1, 5'b01000, 32'h3333_0003, 5'b0);
    next_cycle();
    drive(1'b1, 5'b10000, 32'h4444_0004, 5'b01010);
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o !== 5'b10000 || lane(4) !== 32'h4444_0004) begin
      failures++;
      $display("FAIL multi_drain: v_o=%b lane4=%h expected 10000 44440004", bus.v_o, lane(4));
    end
    drive(1'b0, 5'b0, 32'h0, 5'b10000);
    next_cycle();
    drive(1'b0, 5'b0, 32'h0, 5'b0);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'b00001 << k, 32'hF000_0000 + 32'(k), 5'b0);
      next_cycle();
    end
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    checks++;
    if (bus.v_o !== 5'b11111 || bus.err_o !== 1'b1) begin
      failures++;
      $display("FAIL arst_prefill: v_o=%b err=%b expected 11111 1", bus.v_o, bus.err_o);
    end
    #1 reset_n_i = 1'b0;
    #1;
    checks++;
    if (bus.v_o !== 5'b0 || bus.data_o !== 160'b0 || bus.err_o !== 1'b0 || bus.err_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL arst_immediate: v_o=%b err=%b cnt=%0d data_nonzero=%b expected all zero",
               bus.v_o, bus.err_o, bus.err_cnt_o, |bus.data_o);
    end
    #1 reset_n_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 5'b00001 << k, 32'h0, 5'b0);
      #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin
        failures++;
        $display("FAIL arst_ready lane %0d: got %b expected 1", k, bus.ready_o);
      end
    end
    drive(1'b0, 5'b0, 32'h0, 5'b0);
    next_cycle();
    next_cycle();
    checks++;
    if (bus.v_o !== 5'b0) begin
      failures++;
      $display("FAIL arst_no_stale: v_o=%b expected 00000", bus.v_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_idle_inputs();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_multi_drain();
    test_async_reset();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
